hazard_scoreboard_unit: RTL and testbench

HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

---
 rtl/hazard_scoreboard_unit_pkg.sv | 50 +++++
 rtl/hazard_scoreboard_unit_if.sv | 30 +++
 rtl/hazard_scoreboard_unit_scoreboard.sv | 42 ++++
 rtl/hazard_scoreboard_unit.sv | 101 ++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared opcode constants, control-state type and instruction field helpers
// for the decode-stage hazard unit.
package hazard_pkg;

    localparam int MAX_INSTR_W = 64;
    localparam int MAX_REG_AW  = 8;

    localparam logic [4:0] LOAD       = 5'b10000;
    localparam logic [4:0] STORE      = 5'b10001;
    localparam logic [2:0] JUMP_PFX   = 3'b111;
    localparam logic [2:0] BRANCH_PFX = 3'b101;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_STALL,
        CTRL_FLUSH
    } ctrl_e;

    function automatic logic [4:0] get_opcode(input logic [MAX_INSTR_W-1:0] instr,
                                              input int instr_w);
        return 5'(instr >> (instr_w - 5));
    endfunction

    // idx 0 = dst, 1 = srcA, 2 = srcB, packed directly below the opcode
    function automatic logic [MAX_REG_AW-1:0] get_reg(input logic [MAX_INSTR_W-1:0] instr,
                                                      input int instr_w,
                                                      input int reg_aw,
                                                      input int idx);
        return MAX_REG_AW'((instr >> (instr_w - 5 - (idx + 1) * reg_aw))
                           & ((MAX_INSTR_W'(1) << reg_aw) - MAX_INSTR_W'(1)));
    endfunction

    function automatic logic is_load(input logic [4:0] op);
        return op == LOAD;
    endfunction

    function automatic logic is_jump(input logic [4:0] op);
        return op[4:2] == JUMP_PFX;
    endfunction

    function automatic logic is_branch(input logic [4:0] op);
        return op[4:2] == BRANCH_PFX;
    endfunction

    // ALU formats and the load/store memory format read srcA/srcB
    function automatic logic reads_operands(input logic [4:0] op);
        return !op[4] || (op[4:2] == STORE[4:2]);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Decode-stage bus between the pipeline and the hazard unit: instruction in,
// hold/flush controls and performance counters out.
interface hazard_scoreboard_unit_if #(
    parameter int INSTR_W = 19,
    parameter int CNT_W   = 16
) ();

    logic [INSTR_W-1:0] IF_ID_instruction;
    logic               IF_ID_valid;
    logic               do_branch;
    logic               IF_ID_loadbar;
    logic               IF_ID_flush;
    logic               ID_EX_flush;
    logic               pc_writebar;
    logic [CNT_W-1:0]   stall_count;
    logic [CNT_W-1:0]   flush_count;

    modport master (
        output IF_ID_instruction, IF_ID_valid, do_branch,
        input  IF_ID_loadbar, IF_ID_flush, ID_EX_flush, pc_writebar,
               stall_count, flush_count
    );

    modport slave (
        input  IF_ID_instruction, IF_ID_valid, do_branch,
        output IF_ID_loadbar, IF_ID_flush, ID_EX_flush, pc_writebar,
               stall_count, flush_count
    );

endinterface

// File: rtl/hazard_scoreboard_unit_scoreboard.sv
// Per-register load-pending counters: set to LOAD_LAT by an accepted load,
// counting down to zero; two combinational lookup ports for source operands.
module hazard_scoreboard #(
    parameter int REG_AW   = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int PW   = $clog2(LOAD_LAT + 1);
    localparam int NREG = 1 << REG_AW;

    logic [PW-1:0] pending [NREG];

    // A new load on a register overrides its countdown; r0 is never marked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                pending[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (set_en && (i != 0) && (set_addr == REG_AW'(i))) begin
                    pending[i] <= PW'(LOAD_LAT);
                end else if (pending[i] != '0) begin
                    pending[i] <= pending[i] - PW'(1);
                end
            end
        end
    end

    assign busy_a = (pending[rd_addr_a] != '0);
    assign busy_b = (pending[rd_addr_b] != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Decode-stage hazard unit: load-use stalls from the scoreboard, jump/taken
// branch flushes of wrong-path fetch slots, and saturating event counters.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int INSTR_W     = 19,
    parameter int REG_AW      = 3,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input logic                     clk,
    input logic                     reset,
    hazard_scoreboard_unit_if.slave bus
);

    logic [4:0]        opcode;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] src_a;
    logic [REG_AW-1:0] src_b;
    logic              busy_a;
    logic              busy_b;
    logic              operand_hit;
    logic              flush_start;
    logic              flush_active;
    logic              load_accept;
    logic [1:0]        flush_cnt;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;
    ctrl_e             ctrl;

    assign opcode = get_opcode(MAX_INSTR_W'(bus.IF_ID_instruction), INSTR_W);
    assign dst    = REG_AW'(get_reg(MAX_INSTR_W'(bus.IF_ID_instruction), INSTR_W, REG_AW, 0));
    assign src_a  = REG_AW'(get_reg(MAX_INSTR_W'(bus.IF_ID_instruction), INSTR_W, REG_AW, 1));
    assign src_b  = REG_AW'(get_reg(MAX_INSTR_W'(bus.IF_ID_instruction), INSTR_W, REG_AW, 2));

    // A store's data register is its dst, which is forwarded, so only
    // srcA/srcB are ever looked up
    assign operand_hit = bus.IF_ID_valid && reads_operands(opcode)
                         && (((src_a != '0) && busy_a) || ((src_b != '0) && busy_b));

    assign flush_start  = bus.IF_ID_valid && (flush_cnt == 2'd0)
                          && (is_jump(opcode) || (is_branch(opcode) && bus.do_branch));
    assign flush_active = flush_start || (flush_cnt != 2'd0);

    always_comb begin
        ctrl = CTRL_IDLE;
        if (!reset) begin
            if (flush_active) begin
                ctrl = CTRL_FLUSH;
            end else if (operand_hit) begin
                ctrl = CTRL_STALL;
            end
        end
    end

    assign load_accept = bus.IF_ID_valid && is_load(opcode) && (ctrl == CTRL_IDLE) && (dst != '0);

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (load_accept),
        .set_addr  (dst),
        .rd_addr_a (src_a),
        .rd_addr_b (src_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b)
    );

    // flush_cnt holds the wrong-path slots still to clear after this one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt   <= 2'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (flush_start) begin
                flush_cnt <= 2'(FLUSH_DEPTH - 1);
            end else if (flush_cnt != 2'd0) begin
                flush_cnt <= flush_cnt - 2'd1;
            end
            if ((ctrl == CTRL_STALL) && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if ((ctrl == CTRL_FLUSH) && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    assign bus.IF_ID_loadbar = (ctrl == CTRL_STALL);
    assign bus.pc_writebar   = (ctrl == CTRL_STALL);
    assign bus.ID_EX_flush   = (ctrl == CTRL_STALL);
    assign bus.IF_ID_flush   = (ctrl == CTRL_FLUSH);
    assign bus.stall_count   = stall_count;
    assign bus.flush_count   = flush_count;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: two configurations driven in lockstep,
// checked against a table, directed sequences and a behavioural model.
module tb_hazard_scoreboard_unit;

    localparam int INSTR_W = 19;
    localparam int NDUT    = 2;

    localparam int OP_ADD   = 0;
    localparam int OP_LOAD  = 16;
    localparam int OP_STORE = 17;
    localparam int OP_BR    = 20;
    localparam int OP_NOP   = 24;
    localparam int OP_JMP   = 28;

    typedef struct {
        bit                 v;
        logic [INSTR_W-1:0] ins;
        bit                 br;
        bit [1:0]           ea;
        bit [1:0]           eb;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [INSTR_W-1:0] instr;
    logic               valid;
    logic               branch;

    int errors = 0;
    int checks = 0;

    int pend [NDUT][8];
    int flush_rem [NDUT];
    int m_stall [NDUT];
    int m_flush [NDUT];

    vec_t vq[$];

    always #5 clk = ~clk;

    hazard_scoreboard_unit_if #(.INSTR_W(INSTR_W), .CNT_W(16)) bus_a ();
    hazard_scoreboard_unit_if #(.INSTR_W(INSTR_W), .CNT_W(3))  bus_b ();

    assign bus_a.IF_ID_instruction = instr;
    assign bus_a.IF_ID_valid       = valid;
    assign bus_a.do_branch         = branch;
    assign bus_b.IF_ID_instruction = instr;
    assign bus_b.IF_ID_valid       = valid;
    assign bus_b.do_branch         = branch;

    hazard_scoreboard_unit #(
        .INSTR_W(INSTR_W), .REG_AW(3), .LOAD_LAT(1), .FLUSH_DEPTH(1), .CNT_W(16)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    hazard_scoreboard_unit #(
        .INSTR_W(INSTR_W), .REG_AW(3), .LOAD_LAT(3), .FLUSH_DEPTH(2), .CNT_W(3)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int cmax_of(input int k);
        return (k == 0) ? 65535 : 7;
    endfunction

    function automatic logic [INSTR_W-1:0] mk(input int op, input int d, input int a, input int b);
        return INSTR_W'((op << 14) | (d << 11) | (a << 8) | (b << 5));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            for (int r = 0; r < 8; r++) pend[k][r] = 0;
            flush_rem[k] = 0;
            m_stall[k]   = 0;
            m_flush[k]   = 0;
        end
    endtask

    // Expected stall/flush for the current decode slot from the instruction rules
    task automatic model_predict(input int k, output bit st, output bit fl);
        int iv, op, a, b;
        bit reads;
        iv    = int'(instr);
        op    = iv >> 14;
        a     = (iv >> 8) & 7;
        b     = (iv >> 5) & 7;
        reads = (op < 16) || ((op >> 2) == 4);
        fl    = 1'b0;
        st    = 1'b0;
        if (flush_rem[k] > 0) fl = 1'b1;
        else if (valid && (((op >> 2) == 7) || (((op >> 2) == 5) && branch))) fl = 1'b1;
        if (!fl && valid && reads && ((a != 0 && pend[k][a] > 0) || (b != 0 && pend[k][b] > 0)))
            st = 1'b1;
    endtask

    task automatic model_commit(input int k, input bit st, input bit fl);
        int iv, op, d;
        iv = int'(instr);
        op = iv >> 14;
        d  = (iv >> 11) & 7;
        if (flush_rem[k] > 0) flush_rem[k]--;
        else if (fl) flush_rem[k] = depth_of(k) - 1;
        for (int r = 0; r < 8; r++) if (pend[k][r] > 0) pend[k][r]--;
        if (valid && op == OP_LOAD && !st && !fl && d != 0) pend[k][d] = lat_of(k);
        if (st && m_stall[k] < cmax_of(k)) m_stall[k]++;
        if (fl && m_flush[k] < cmax_of(k)) m_flush[k]++;
    endtask

    task automatic read_dut(input int k, output logic [3:0] ctl, output logic [31:0] sc, output logic [31:0] fc);
        if (k == 0) begin
            ctl = {bus_a.IF_ID_loadbar, bus_a.pc_writebar, bus_a.ID_EX_flush, bus_a.IF_ID_flush};
            sc  = 32'(bus_a.stall_count);
            fc  = 32'(bus_a.flush_count);
        end else begin
            ctl = {bus_b.IF_ID_loadbar, bus_b.pc_writebar, bus_b.ID_EX_flush, bus_b.IF_ID_flush};
            sc  = 32'(bus_b.stall_count);
            fc  = 32'(bus_b.flush_count);
        end
    endtask

    task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [INSTR_W-1:0] ins, input bit br);
        @(posedge clk);
        #1;
        valid  = v;
        instr  = ins;
        branch = br;
    endtask

    // Called at the falling edge: compare, then advance the model one cycle
    task automatic checkOutput(input string name, input bit use_tab, input bit [1:0] ta, input bit [1:0] tb2);
        bit          st, fl;
        logic [3:0]  ctl;
        logic [31:0] sc, fc;
        for (int k = 0; k < NDUT; k++) begin
            model_predict(k, st, fl);
            read_dut(k, ctl, sc, fc);
            cmp({name, "/ctl"}, k, 32'(ctl), 32'({st, st, st, fl}));
            cmp({name, "/stall_count"}, k, sc, 32'(m_stall[k]));
            cmp({name, "/flush_count"}, k, fc, 32'(m_flush[k]));
            if (use_tab) cmp({name, "/table"}, k, 32'({ctl[3], ctl[0]}), 32'((k == 0) ? ta : tb2));
            model_commit(k, st, fl);
        end
    endtask

    task automatic run_vec(input string name, input bit v, input logic [INSTR_W-1:0] ins, input bit br,
                           input bit use_tab, input bit [1:0] ta, input bit [1:0] tb2);
        applyStimulus(v, ins, br);
        @(negedge clk);
        checkOutput(name, use_tab, ta, tb2);
    endtask

    task automatic check_reset_zero(input string name);
        logic [3:0]  ctl;
        logic [31:0] sc, fc;
        for (int k = 0; k < NDUT; k++) begin
            read_dut(k, ctl, sc, fc);
            cmp({name, "/ctl"}, k, 32'(ctl), 32'(0));
            cmp({name, "/stall_count"}, k, sc, 32'(0));
            cmp({name, "/flush_count"}, k, fc, 32'(0));
        end
    endtask

    // Reset asserted mid-cycle, held across one edge, released just after it
    task automatic pulse_reset(input string name);
        #2;
        reset = 1'b1;
        #1;
        check_reset_zero(name);
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          op_pool [10];
        logic [31:0] sc, fc;
        logic [3:0]  ctl;

        op_pool = '{0, 3, 16, 17, 18, 20, 21, 24, 28, 31};

        // {valid, instr, do_branch, {stall,flush} for LAT1/FD1, same for LAT3/FD2}
        vq.push_back('{1'b0, mk(OP_ADD, 1, 3, 2),   1'b0, 2'b00, 2'b00});
        vq.push_back('{1'b1, mk(OP_LOAD, 3, 2, 0),  1'b0, 2'b00, 2'b00});
        vq.push_back('{1'b1, mk(OP_ADD, 1, 3, 2),   1'b0, 2'b10, 2'b10});
        vq.push_back('{1'b1, mk(OP_ADD, 1, 3, 2),   1'b0, 2'b00, 2'b10});
        vq.push_back('{1'b1, mk(OP_ADD, 1, 3, 2),   1'b0, 2'b00, 2'b10});
        vq.push_back('{1'b1, mk(OP_ADD, 1, 3, 2),   1'b0, 2'b00, 2'b00});
        vq.push_back('{1'b1, mk(OP_LOAD, 0, 2, 0),  1'b0, 2'b00, 2'b00});
        vq.push_back('{1'b1, mk(OP_ADD, 1, 0, 0),   1'b0, 2'b00, 2'b00});
        vq.push_back('{1'b1, mk(OP_LOAD, 3, 2, 0),  1'b0, 2'b00, 2'b00});
        vq.push_back('{1'b1, mk(OP_STORE, 3, 2, 0), 1'b0, 2'b00, 2'b00});
        vq.push_back('{1'b1, mk(OP_LOAD, 3, 2, 0),  1'b0, 2'b00, 2'b00});
        vq.push_back('{1'b1, mk(OP_STORE, 1, 3, 0), 1'b0, 2'b10, 2'b10});
        vq.push_back('{1'b1, mk(OP_STORE, 1, 3, 0), 1'b0, 2'b00, 2'b10});
        vq.push_back('{1'b1, mk(OP_JMP, 0, 0, 0),   1'b0, 2'b01, 2'b01});
        vq.push_back('{1'b1, mk(OP_JMP, 0, 0, 0),   1'b0, 2'b01, 2'b01});
        vq.push_back('{1'b1, mk(OP_NOP, 0, 0, 0),   1'b0, 2'b00, 2'b00});
        vq.push_back('{1'b1, mk(OP_BR, 0, 0, 0),    1'b0, 2'b00, 2'b00});
        vq.push_back('{1'b1, mk(OP_LOAD, 5, 0, 0),  1'b0, 2'b00, 2'b00});
        vq.push_back('{1'b1, mk(OP_BR, 0, 0, 0),    1'b1, 2'b01, 2'b01});
        vq.push_back('{1'b1, mk(OP_LOAD, 6, 0, 0),  1'b0, 2'b00, 2'b01});
        vq.push_back('{1'b1, mk(OP_ADD, 1, 6, 0),   1'b0, 2'b10, 2'b00});
        vq.push_back('{1'b1, mk(OP_ADD, 1, 6, 0),   1'b0, 2'b00, 2'b00});

        reset  = 1'b1;
        valid  = 1'b0;
        instr  = '0;
        branch = 1'b0;
        model_reset();
        #12;
        check_reset_zero("reset_state");
        @(posedge clk);
        #2;
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            run_vec($sformatf("table%0d", i), vq[i].v, vq[i].ins, vq[i].br, 1'b1, vq[i].ea, vq[i].eb);
        end

        // Reset during the third stall cycle of the LAT3 instance
        run_vec("rst_load", 1'b1, mk(OP_LOAD, 3, 0, 0), 1'b0, 1'b1, 2'b00, 2'b00);
        run_vec("rst_stall1", 1'b1, mk(OP_ADD, 1, 3, 0), 1'b0, 1'b1, 2'b10, 2'b10);
        run_vec("rst_stall2", 1'b1, mk(OP_ADD, 1, 3, 0), 1'b0, 1'b1, 2'b00, 2'b10);
        applyStimulus(1'b1, mk(OP_ADD, 1, 3, 0), 1'b0);
        pulse_reset("reset_mid_stall");
        @(negedge clk);
        checkOutput("after_reset", 1'b1, 2'b00, 2'b00);

        // Counter saturation: the 3-bit counters must stick at 7
        pulse_reset("reset_before_sat");
        for (int i = 0; i < 10; i++) begin
            run_vec("sat_load", 1'b1, mk(OP_LOAD, 2, 0, 0), 1'b0, 1'b1, 2'b00, 2'b00);
            run_vec("sat_use", 1'b1, mk(OP_ADD, 1, 2, 0), 1'b0, 1'b1, 2'b10, 2'b10);
        end
        for (int i = 0; i < 10; i++) begin
            run_vec("sat_jump", 1'b1, mk(OP_JMP, 0, 0, 0), 1'b0, 1'b1, 2'b01, 2'b01);
            run_vec("sat_slot2", 1'b1, mk(OP_NOP, 0, 0, 0), 1'b0, 1'b1, 2'b00, 2'b01);
        end
        run_vec("sat_idle", 1'b0, '0, 1'b0, 1'b0, 2'b00, 2'b00);
        read_dut(0, ctl, sc, fc);
        cmp("sat_stall_wide", 0, sc, 32'd10);
        cmp("sat_flush_wide", 0, fc, 32'd10);
        read_dut(1, ctl, sc, fc);
        cmp("sat_stall_narrow", 1, sc, 32'd7);
        cmp("sat_flush_narrow", 1, fc, 32'd7);

        for (int i = 0; i < 400; i++) begin
            logic [INSTR_W-1:0] ins;
            ins = mk(op_pool[$urandom_range(0, 9)], int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            run_vec("random", ($urandom_range(0, 9) != 0), ins, 1'($urandom_range(0, 1)),
                    1'b0, 2'b00, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
